// File: rtl/neander_core_param.sv
// Neander accumulator CPU with parameterised data/address widths.
// Multi-cycle FSM (FETCH, DECODE, ADDR, OPER, STORE, HALT) driving a single
// request/ready memory port. Memory strobes and address are Moore outputs.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   mem_addr              memory address (PC or REM depending on state)
//   mem_data_out          write data, always AC
//   mem_data_in           read data, sampled on the edge with mem_ready=1
//   mem_read, mem_write   request strobes, held until mem_ready
//   mem_ready             memory accepts/completes the current request
//   start                 leave HALT and resume fetching at the current PC
//   halted                high while in HALT
//   dbg_pc/ac/ri/flags    live architectural state, flags are {N, Z, C}
module neander_core_param #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  input  logic              start,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [DATA_W-1:0] dbg_ac,
  output logic [DATA_W-1:0] dbg_ri,
  output logic [2:0]        dbg_flags
);

  typedef enum logic [2:0] {StFetch, StDecode, StAddr, StOper, StStore, StHalt} state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpSta = 4'h1;
  localparam logic [3:0] OpLda = 4'h2;
  localparam logic [3:0] OpAdd = 4'h3;
  localparam logic [3:0] OpOr  = 4'h4;
  localparam logic [3:0] OpAnd = 4'h5;
  localparam logic [3:0] OpNot = 4'h6;
  localparam logic [3:0] OpJmp = 4'h8;
  localparam logic [3:0] OpJn  = 4'h9;
  localparam logic [3:0] OpJz  = 4'hA;
  localparam logic [3:0] OpHlt = 4'hF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, rem_q, rem_d;
  logic [DATA_W-1:0] ac_q, ac_d, ri_q, ri_d;
  logic              n_q, n_d, z_q, z_d, c_q, c_d;
  logic              upd_nz;
  logic [3:0]        opcode;
  logic [DATA_W:0]   sum;

  assign opcode = ri_q[DATA_W-1 -: 4];
  assign sum    = {1'b0, ac_q} + {1'b0, mem_data_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= ADDR_W'(RESET_PC);
      rem_q   <= '0;
      ac_q    <= '0;
      ri_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rem_q   <= rem_d;
      ac_q    <= ac_d;
      ri_q    <= ri_d;
      n_q     <= n_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rem_d   = rem_q;
    ac_d    = ac_q;
    ri_d    = ri_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    upd_nz  = 1'b0;

    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          ri_d    = mem_data_in;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (opcode)
          OpNot: begin
            ac_d    = ~ac_q;
            upd_nz  = 1'b1;
            state_d = StFetch;
          end
          OpHlt: state_d = StHalt;
          // Untaken conditional jumps skip their operand word.
          OpJn: begin
            if (n_q) begin
              state_d = StAddr;
            end else begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = StFetch;
            end
          end
          OpJz: begin
            if (z_q) begin
              state_d = StAddr;
            end else begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = StFetch;
            end
          end
          OpJmp, OpSta, OpLda, OpAdd, OpOr, OpAnd: state_d = StAddr;
          default: state_d = StFetch;  // NOP and unassigned opcodes
        endcase
      end
      StAddr: begin
        if (mem_ready) begin
          // Only taken jumps ever reach ADDR with a jump opcode.
          if (opcode == OpJmp || opcode == OpJn || opcode == OpJz) begin
            pc_d    = mem_data_in[ADDR_W-1:0];
            state_d = StFetch;
          end else begin
            rem_d   = mem_data_in[ADDR_W-1:0];
            pc_d    = pc_q + ADDR_W'(1);
            state_d = (opcode == OpSta) ? StStore : StOper;
          end
        end
      end
      StOper: begin
        if (mem_ready) begin
          case (opcode)
            OpLda: ac_d = mem_data_in;
            OpAdd: begin
              ac_d = sum[DATA_W-1:0];
              c_d  = sum[DATA_W];
            end
            OpOr:    ac_d = ac_q | mem_data_in;
            OpAnd:   ac_d = ac_q & mem_data_in;
            default: ac_d = ac_q;
          endcase
          upd_nz  = 1'b1;
          state_d = StFetch;
        end
      end
      StStore: begin
        if (mem_ready) state_d = StFetch;
      end
      StHalt: begin
        if (start) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (upd_nz) begin
      n_d = ac_d[DATA_W-1];
      z_d = (ac_d == '0);
    end
  end

  // Strobes are gated by reset so an in-flight access drops without a clock edge.
  assign mem_read     = ~reset & (state_q == StFetch || state_q == StAddr || state_q == StOper);
  assign mem_write    = ~reset & (state_q == StStore);
  assign mem_addr     = (state_q == StOper || state_q == StStore) ? rem_q : pc_q;
  assign mem_data_out = ac_q;
  assign halted       = (state_q == StHalt);
  assign dbg_pc       = pc_q;
  assign dbg_ac       = ac_q;
  assign dbg_ri       = ri_q;
  assign dbg_flags    = {n_q, z_q, c_q};

endmodule

// File: tb/tb_neander_core_param.sv
// Directed bench for neander_core_param: a default 8/8 instance and a 16/10 instance,
// each with its own behavioural memory.
module tb_neander_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // 8-bit instance
  logic       reset8, ready8, start8;
  logic [7:0] addr8, dout8, din8, pc8, ac8, ri8;
  logic       rd8, wr8, halted8;
  logic [2:0] flags8;
  logic [7:0] mem8 [256];
  assign din8 = mem8[addr8];

  neander_core_param u_dut8 (
    .clk(clk), .reset(reset8), .mem_addr(addr8), .mem_data_out(dout8),
    .mem_data_in(din8), .mem_read(rd8), .mem_write(wr8), .mem_ready(ready8),
    .start(start8), .halted(halted8), .dbg_pc(pc8), .dbg_ac(ac8), .dbg_ri(ri8),
    .dbg_flags(flags8)
  );

  // 16-bit data, 10-bit address instance
  logic        reset16, ready16, start16;
  logic [9:0]  addr16, pc16;
  logic [15:0] dout16, din16, ac16, ri16;
  logic        rd16, wr16, halted16;
  logic [2:0]  flags16;
  logic [15:0] mem16 [1024];
  assign din16 = mem16[addr16];

  neander_core_param #(.DATA_W(16), .ADDR_W(10), .RESET_PC(0)) u_dut16 (
    .clk(clk), .reset(reset16), .mem_addr(addr16), .mem_data_out(dout16),
    .mem_data_in(din16), .mem_read(rd16), .mem_write(wr16), .mem_ready(ready16),
    .start(start16), .halted(halted16), .dbg_pc(pc16), .dbg_ac(ac16), .dbg_ri(ri16),
    .dbg_flags(flags16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; memory writes commit on the edge where write and ready are both high.
  task automatic tick();
    logic       w8, w16;
    logic [7:0] a8, d8;
    logic [9:0] a16;
    logic [15:0] d16;
    w8 = wr8 && ready8;   a8 = addr8;   d8 = dout8;
    w16 = wr16 && ready16; a16 = addr16; d16 = dout16;
    @(posedge clk);
    if (w8) mem8[a8] = d8;
    if (w16) mem16[a16] = d16;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_halt8(input int bound, output int cyc);
    cyc = 0;
    while (!halted8 && cyc < bound) begin
      tick();
      cyc++;
    end
  endtask

  task automatic clear8();
    for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
  endtask

  // Three cycles with ready low: request and address must not move.
  task automatic stall3(input string tag, input logic [7:0] exp_addr);
    ready8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_addr"}, addr8, exp_addr);
      chk({tag, "_rd"}, rd8, 1'b1);
    end
    ready8 = 1'b1;
    tick();
  endtask

  int cyc;

  initial begin
    reset8 = 1'b1; ready8 = 1'b1; start8 = 1'b0;
    reset16 = 1'b1; ready16 = 1'b1; start16 = 1'b0;
    clear8();
    for (int i = 0; i < 1024; i++) mem16[i] = 16'h0000;
    #1;
    // Reset values, no clock edge yet
    chk("rst_pc", pc8, 8'h00);
    chk("rst_ac", ac8, 8'h00);
    chk("rst_ri", ri8, 8'h00);
    chk("rst_flags", flags8, 3'b010);
    chk("rst_halted", halted8, 1'b0);
    chk("rst_wr", wr8, 1'b0);
    chk("rst_rd", rd8, 1'b0);

    // LDA 80, ADD 81, STA 82, HLT
    mem8[0] = 8'h20; mem8[1] = 8'h80; mem8[2] = 8'h30; mem8[3] = 8'h81;
    mem8[4] = 8'h10; mem8[5] = 8'h82; mem8[6] = 8'hF0;
    mem8[8'h80] = 8'h05; mem8[8'h81] = 8'hFE;
    reset8 = 1'b0;
    #1;
    chk("first_fetch_addr", addr8, 8'h00);
    chk("first_fetch_rd", rd8, 1'b1);
    run_to_halt8(100, cyc);
    chk("prog_cycles", cyc, 14);
    chk("prog_mem82", mem8[8'h82], 8'h03);
    chk("prog_ac", ac8, 8'h03);
    chk("prog_flags", flags8, 3'b001);
    chk("prog_halted", halted8, 1'b1);
    chk("prog_pc", pc8, 8'h07);
    chk("halt_rd", rd8, 1'b0);
    chk("halt_addr", addr8, 8'h07);

    // HLT at 05, start ignored while running, start resumes from 06
    reset8 = 1'b1; clear8();
    mem8[5] = 8'hF0;
    #1 reset8 = 1'b0;
    ticks(3);
    start8 = 1'b1; tick(); start8 = 1'b0;
    run_to_halt8(100, cyc);
    chk("hlt_cycles", cyc + 4, 12);
    chk("hlt_halted", halted8, 1'b1);
    chk("hlt_pc", pc8, 8'h06);
    mem8[6] = 8'hF0;
    ticks(2);
    chk("hlt_stay", halted8, 1'b1);
    start8 = 1'b1; tick(); start8 = 1'b0;
    chk("resume_halted", halted8, 1'b0);
    chk("resume_rd", rd8, 1'b1);
    chk("resume_addr", addr8, 8'h06);
    ticks(2);
    chk("rehalt", halted8, 1'b1);
    chk("rehalt_pc", pc8, 8'h07);

    // Jumps and logic ops
    reset8 = 1'b1; clear8();
    mem8[8'h00] = 8'hA0; mem8[8'h01] = 8'h10;  // JZ 10 (taken)
    mem8[8'h10] = 8'h90; mem8[8'h11] = 8'h20;  // JN 20 (untaken)
    mem8[8'h12] = 8'h60;                       // NOT
    mem8[8'h13] = 8'h90; mem8[8'h14] = 8'h40;  // JN 40 (taken)
    mem8[8'h40] = 8'hA0; mem8[8'h41] = 8'h50;  // JZ 50 (untaken)
    mem8[8'h42] = 8'h20; mem8[8'h43] = 8'h60;  // LDA 60
    mem8[8'h44] = 8'h40; mem8[8'h45] = 8'h61;  // OR 61
    mem8[8'h46] = 8'h50; mem8[8'h47] = 8'h62;  // AND 62
    mem8[8'h48] = 8'h50; mem8[8'h49] = 8'h63;  // AND 63
    mem8[8'h4A] = 8'h30; mem8[8'h4B] = 8'h64;  // ADD 64
    mem8[8'h60] = 8'h0F; mem8[8'h61] = 8'hF0; mem8[8'h62] = 8'h3C;
    mem8[8'h63] = 8'h00; mem8[8'h64] = 8'h01;
    #1 reset8 = 1'b0;
    ticks(3);
    chk("jz_taken_pc", pc8, 8'h10);
    chk("jz_taken_addr", addr8, 8'h10);
    chk("jz_taken_rd", rd8, 1'b1);
    ticks(2);
    chk("jn_untaken_pc", pc8, 8'h12);
    ticks(2);
    chk("not_ac", ac8, 8'hFF);
    chk("not_flags", flags8, 3'b100);
    ticks(3);
    chk("jn_taken_pc", pc8, 8'h40);
    ticks(2);
    chk("jz_untaken_pc", pc8, 8'h42);
    ticks(4);
    chk("lda_ac", ac8, 8'h0F);
    chk("lda_flags", flags8, 3'b000);
    ticks(4);
    chk("or_ac", ac8, 8'hFF);
    chk("or_flags", flags8, 3'b100);
    ticks(4);
    chk("and_ac", ac8, 8'h3C);
    chk("and_flags", flags8, 3'b000);
    ticks(4);
    chk("and0_ac", ac8, 8'h00);
    chk("and0_flags", flags8, 3'b010);
    ticks(4);
    chk("add_ac", ac8, 8'h01);
    chk("add_flags", flags8, 3'b000);

    // LDA with three wait cycles on every access: 13 cycles total
    reset8 = 1'b1; clear8();
    mem8[0] = 8'h20; mem8[1] = 8'h80; mem8[8'h80] = 8'h05;
    #1 reset8 = 1'b0;
    stall3("stall_fetch", 8'h00);
    tick();
    stall3("stall_addr", 8'h01);
    stall3("stall_oper", 8'h80);
    chk("stall_ac", ac8, 8'h05);
    chk("stall_pc", pc8, 8'h02);
    chk("stall_next_addr", addr8, 8'h02);

    // Reset while STORE waits: write strobe drops with no edge, memory untouched
    reset8 = 1'b1; clear8();
    mem8[0] = 8'h10; mem8[1] = 8'h90; mem8[8'h90] = 8'hAA;
    #1 reset8 = 1'b0;
    ticks(3);
    ready8 = 1'b0;
    chk("store_wr", wr8, 1'b1);
    chk("store_rd", rd8, 1'b0);
    chk("store_addr", addr8, 8'h90);
    tick();
    chk("store_wait_wr", wr8, 1'b1);
    #2 reset8 = 1'b1;
    #1;
    chk("rst_drop_wr", wr8, 1'b0);
    chk("rst_drop_rd", rd8, 1'b0);
    reset8 = 1'b0;
    ready8 = 1'b1;
    #1;
    chk("refetch_addr", addr8, 8'h00);
    chk("refetch_rd", rd8, 1'b1);
    tick();
    chk("store_abandoned", mem8[8'h90], 8'hAA);
    chk("refetch_ri", ri8, 8'h10);

    // 16/10 instance: opcode from bits 15:12, NOT, PC wrap at 3FF
    mem16[10'h000] = 16'h0600;  // NOP (low nibble pattern of NOT must not decode)
    mem16[10'h001] = 16'h6000;  // NOT
    mem16[10'h002] = 16'h8000;  // JMP 3FF
    mem16[10'h003] = 16'h03FF;
    mem16[10'h3FF] = 16'hF000;  // HLT
    chk("w16_rst_flags", flags16, 3'b010);
    reset16 = 1'b0;
    ticks(2);
    chk("w16_nop_ac", ac16, 16'h0000);
    ticks(2);
    chk("w16_not_ac", ac16, 16'hFFFF);
    chk("w16_not_flags", flags16, 3'b100);
    ticks(3);
    chk("w16_jmp_pc", pc16, 10'h3FF);
    tick();
    chk("w16_wrap_pc", pc16, 10'h000);
    chk("w16_ri", ri16, 16'hF000);
    tick();
    chk("w16_halted", halted16, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
